// File: rtl/score_grader.sv
// Grades fixed-size windows of DTW distance samples against three thresholds
// and keeps combo / max-combo / point totals for one song.
module score_grader #(
  parameter int WIDTH      = 32,
  parameter int WINDOW     = 16,
  parameter int TH_PERFECT = 100,
  parameter int TH_GOOD    = 400,
  parameter int TH_OK      = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] score_in,
  input  logic             score_valid,
  output logic [1:0]       grade,
  output logic             grade_valid,
  output logic [15:0]      combo,
  output logic [15:0]      max_combo,
  output logic [31:0]      total_points,
  output logic             busy,
  output logic             done
);

  localparam int LOG2W = $clog2(WINDOW);
  localparam int SUM_W = WIDTH + LOG2W;
  localparam logic [LOG2W-1:0] LAST_CNT = LOG2W'(WINDOW - 1);
  localparam logic [WIDTH-1:0] LIM_PERFECT = WIDTH'(TH_PERFECT);
  localparam logic [WIDTH-1:0] LIM_GOOD    = WIDTH'(TH_GOOD);
  localparam logic [WIDTH-1:0] LIM_OK      = WIDTH'(TH_OK);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t            state, state_next;
  logic [SUM_W-1:0]  sum;
  logic [LOG2W-1:0]  count;

  logic              start_ok;
  logic              accept;
  logic              window_end;
  logic [SUM_W-1:0]  sum_plus;
  logic [WIDTH-1:0]  avg_next;
  logic [1:0]        grade_next;
  logic [31:0]       points_add;
  logic [15:0]       combo_next;
  logic [15:0]       max_next;
  logic [32:0]       points_sum;
  logic [31:0]       total_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          start_ok   = 1'b1;
          state_next = RUN;
        end
      end
      RUN:     if (stop) state_next = FLUSH;
      FLUSH:   state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN) || (state == FLUSH);
  assign done = (state == DONE);

  // The window is judged straight from sum+score_in on the completing edge,
  // so grade_valid itself acts as the one-cycle pending flag.
  always_comb begin
    accept     = (state == RUN) && score_valid;
    window_end = accept && (count == LAST_CNT);
    sum_plus   = sum + SUM_W'(score_in);
    avg_next   = sum_plus[SUM_W-1:LOG2W];
    grade_next = 2'd0;
    points_add = 32'd0;
    if (avg_next <= LIM_PERFECT) begin
      grade_next = 2'd3;
      points_add = 32'd100;
    end else if (avg_next <= LIM_GOOD) begin
      grade_next = 2'd2;
      points_add = 32'd50;
    end else if (avg_next <= LIM_OK) begin
      grade_next = 2'd1;
      points_add = 32'd10;
    end
    if (grade_next == 2'd0)     combo_next = 16'd0;
    else if (combo == 16'hFFFF) combo_next = combo;
    else                        combo_next = combo + 16'd1;
    max_next   = (combo_next > max_combo) ? combo_next : max_combo;
    points_sum = {1'b0, total_points} + {1'b0, points_add};
    total_next = points_sum[32] ? 32'hFFFF_FFFF : points_sum[31:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum          <= '0;
      count        <= '0;
      grade        <= 2'd0;
      grade_valid  <= 1'b0;
      combo        <= 16'd0;
      max_combo    <= 16'd0;
      total_points <= 32'd0;
    end else begin
      grade_valid <= 1'b0;
      if (start_ok) begin
        sum          <= '0;
        count        <= '0;
        grade        <= 2'd0;
        combo        <= 16'd0;
        max_combo    <= 16'd0;
        total_points <= 32'd0;
      end else if (window_end) begin
        sum          <= '0;
        count        <= '0;
        grade        <= grade_next;
        grade_valid  <= 1'b1;
        combo        <= combo_next;
        max_combo    <= max_next;
        total_points <= total_next;
      end else if (accept) begin
        sum   <= sum_plus;
        count <= count + 1'b1;
      end else if (state == FLUSH) begin
        // A partial window left over at the end of a song is dropped.
        sum   <= '0;
        count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_score_grader.sv
// Directed, table-driven check of score_grader with a 4-sample window,
// plus hand-written sequences for asynchronous reset in mid-window.
module tb_score_grader;

  localparam int WIDTH  = 32;
  localparam int WINDOW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] score_in;
  logic             score_valid;
  logic [1:0]       grade;
  logic             grade_valid;
  logic [15:0]      combo;
  logic [15:0]      max_combo;
  logic [31:0]      total_points;
  logic             busy;
  logic             done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  score_grader #(
    .WIDTH(WIDTH), .WINDOW(WINDOW),
    .TH_PERFECT(100), .TH_GOOD(400), .TH_OK(1000)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .score_in(score_in), .score_valid(score_valid),
    .grade(grade), .grade_valid(grade_valid), .combo(combo),
    .max_combo(max_combo), .total_points(total_points),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic        st;
    logic        sp;
    logic        sv;
    logic [31:0] data;
    logic [1:0]  g;
    logic        gv;
    logic [15:0] c;
    logic [15:0] mc;
    logic [31:0] tp;
    logic        b;
    logic        d;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic st, input logic sp, input logic sv,
                                 input logic [31:0] data, input logic [1:0] g,
                                 input logic gv, input logic [15:0] c,
                                 input logic [15:0] mc, input logic [31:0] tp,
                                 input logic b, input logic d);
    vec_t v;
    v.st = st; v.sp = sp; v.sv = sv; v.data = data;
    v.g = g; v.gv = gv; v.c = c; v.mc = mc; v.tp = tp; v.b = b; v.d = d;
    vecs.push_back(v);
  endfunction

  // Drive inputs, let one rising edge pass, return 1 time unit after it.
  task automatic applyStimulus(input logic st, input logic sp, input logic sv,
                               input logic [31:0] data);
    start       = st;
    stop        = sp;
    score_valid = sv;
    score_in    = data;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] g,
                             input logic gv, input logic [15:0] c,
                             input logic [15:0] mc, input logic [31:0] tp,
                             input logic b, input logic d);
    checks++;
    if ({grade, grade_valid, combo, max_combo, total_points, busy, done} !==
        {g, gv, c, mc, tp, b, d}) begin
      failures++;
      $display("[TB] FAIL %s: got grade=%0d gv=%0b combo=%0d max=%0d pts=%0d busy=%0b done=%0b, expected grade=%0d gv=%0b combo=%0d max=%0d pts=%0d busy=%0b done=%0b",
               name, grade, grade_valid, combo, max_combo, total_points, busy, done,
               g, gv, c, mc, tp, b, d);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    stop        = 1'b0;
    score_valid = 1'b0;
    score_in    = '0;
    #2;
    checkOutput("reset", 2'd0, 1'b0, 16'd0, 16'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus(1'b0, 1'b0, 1'b1, 32'd50);
    checkOutput("idle_ignores_valid", 2'd0, 1'b0, 16'd0, 16'd0, 32'd0, 1'b0, 1'b0);

    //     st sp sv data             g  gv combo max  pts  busy done
    addVec(1, 0, 0, 32'd0,           0, 0, 0,    0,   0,   1,   0);
    addVec(0, 0, 1, 32'd50,          0, 0, 0,    0,   0,   1,   0);
    addVec(0, 0, 1, 32'd50,          0, 0, 0,    0,   0,   1,   0);
    addVec(0, 0, 1, 32'd50,          0, 0, 0,    0,   0,   1,   0);
    addVec(0, 0, 1, 32'd50,          3, 1, 1,    1,   100, 1,   0);
    addVec(0, 0, 1, 32'd200,         3, 0, 1,    1,   100, 1,   0);
    addVec(0, 0, 1, 32'd300,         3, 0, 1,    1,   100, 1,   0);
    addVec(0, 0, 1, 32'd500,         3, 0, 1,    1,   100, 1,   0);
    addVec(0, 0, 1, 32'd600,         2, 1, 2,    2,   150, 1,   0);
    addVec(0, 0, 1, 32'd1001,        2, 0, 2,    2,   150, 1,   0);
    addVec(0, 0, 1, 32'd1001,        2, 0, 2,    2,   150, 1,   0);
    addVec(0, 0, 1, 32'd1001,        2, 0, 2,    2,   150, 1,   0);
    addVec(0, 0, 1, 32'd1001,        0, 1, 0,    2,   150, 1,   0);
    addVec(0, 0, 1, 32'hFFFF_FFFF,   0, 0, 0,    2,   150, 1,   0);
    addVec(0, 0, 1, 32'hFFFF_FFFF,   0, 0, 0,    2,   150, 1,   0);
    addVec(0, 0, 1, 32'hFFFF_FFFF,   0, 0, 0,    2,   150, 1,   0);
    addVec(0, 0, 1, 32'hFFFF_FFFF,   0, 1, 0,    2,   150, 1,   0);
    // Sum reaches exactly 2^32: avg 2^30 is a MISS only if no bit is lost.
    addVec(0, 0, 1, 32'hFFFF_FFFF,   0, 0, 0,    2,   150, 1,   0);
    addVec(0, 0, 1, 32'd1,           0, 0, 0,    2,   150, 1,   0);
    addVec(0, 0, 1, 32'd0,           0, 0, 0,    2,   150, 1,   0);
    addVec(0, 0, 1, 32'd0,           0, 1, 0,    2,   150, 1,   0);
    addVec(0, 0, 1, 32'd10,          0, 0, 0,    2,   150, 1,   0);
    addVec(0, 0, 1, 32'd10,          0, 0, 0,    2,   150, 1,   0);
    addVec(0, 1, 0, 32'd0,           0, 0, 0,    2,   150, 1,   0);
    addVec(0, 0, 0, 32'd0,           0, 0, 0,    2,   150, 0,   1);
    addVec(0, 1, 1, 32'd0,           0, 0, 0,    2,   150, 0,   1);
    addVec(0, 0, 1, 32'd5,           0, 0, 0,    2,   150, 0,   1);
    addVec(1, 0, 0, 32'd0,           0, 0, 0,    0,   0,   1,   0);
    addVec(0, 0, 1, 32'd80,          0, 0, 0,    0,   0,   1,   0);
    addVec(1, 0, 1, 32'd80,          0, 0, 0,    0,   0,   1,   0);
    addVec(0, 0, 1, 32'd80,          0, 0, 0,    0,   0,   1,   0);
    addVec(0, 1, 1, 32'd80,          3, 1, 1,    1,   100, 1,   0);
    addVec(0, 0, 0, 32'd0,           3, 0, 1,    1,   100, 0,   1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].st, vecs[i].sp, vecs[i].sv, vecs[i].data);
      checkOutput($sformatf("vec%0d", i), vecs[i].g, vecs[i].gv, vecs[i].c,
                  vecs[i].mc, vecs[i].tp, vecs[i].b, vecs[i].d);
    end

    // New song with one graded window, then a partial window and async reset.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("restart", 2'd0, 1'b0, 16'd0, 16'd0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 32'd50);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd50);
    checkOutput("pre_reset_window", 2'd3, 1'b1, 16'd1, 16'd1, 32'd100, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 32'd5000);
    checkOutput("partial_window", 2'd3, 1'b0, 16'd1, 16'd1, 32'd100, 1'b1, 1'b0);
    score_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset", 2'd0, 1'b0, 16'd0, 16'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("start_after_reset", 2'd0, 1'b0, 16'd0, 16'd0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'd500);
      checkOutput($sformatf("post_reset_sample%0d", i), 2'd0, 1'b0, 16'd0, 16'd0,
                  32'd0, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd500);
    checkOutput("post_reset_ok", 2'd1, 1'b1, 16'd1, 16'd1, 32'd10, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("grade_holds", 2'd1, 1'b0, 16'd1, 16'd1, 32'd10, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_grader.md
# score_grader

Downstream consumer of the DTW accelerator's 32-bit distance stream in the game loop. Accumulates distance samples into fixed-size judgement windows and grades each window's average against three thresholds. Maintains combo, max-combo and point totals for a song, bracketed by start/stop controls from the game controller.

## Interface
- WIDTH, 32, width of incoming DTW distance samples
- WINDOW, 16, samples per judgement window; power of two, at least 2
- TH_PERFECT, 100, max average distance (inclusive) for grade 3
- TH_GOOD, 400, max average distance (inclusive) for grade 2
- TH_OK, 1000, max average distance (inclusive) for grade 1
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a song; honoured only in IDLE or DONE
- stop  input  1  end a song; honoured only in RUN
- score_in  input  WIDTH  DTW distance sample; lower is better
- score_valid  input  1  score_in valid this cycle; no backpressure
- grade  output  2  3=PERFECT, 2=GOOD, 1=OK, 0=MISS; holds last value
- grade_valid  output  1  one-cycle pulse per completed window
- combo  output  16  consecutive non-MISS windows, saturating
- max_combo  output  16  highest combo this song
- total_points  output  32  saturating song point total
- busy  output  1  high in RUN and FLUSH
- done  output  1  high in DONE

## Operation
- States: IDLE, RUN, FLUSH, DONE. Reset enters IDLE.
- IDLE/DONE, start=1: clear sum, sample count, pending flag, combo, max_combo, total_points, grade. Go to RUN next cycle.
- RUN: each cycle with score_valid=1 accepts one sample. sum += score_in, count += 1.
- Sum register is WIDTH+log2(WINDOW) bits and cannot overflow.
- When the accepted sample is the WINDOW-th:
  - latch avg = (sum + score_in) >> log2(WINDOW) (truncating);
  - set pending; clear sum and count in the same cycle.
  - The next sample may be accepted the following cycle with no bubble.
- Judgement, in the cycle after pending is set:
  - avg <= TH_PERFECT: grade 3, +100 points;
  - else avg <= TH_GOOD: grade 2, +50;
  - else avg <= TH_OK: grade 1, +10;
  - else grade 0, +0.
- Non-MISS: combo += 1, saturating at 16'hFFFF. MISS: combo = 0.
- max_combo = max(max_combo, new combo). total_points saturates at 32'hFFFFFFFF.
- RUN, stop=1: go to FLUSH. A sample with score_valid in the same cycle is still accepted. If it completes a window, it is judged.
- FLUSH (exactly one cycle): issue any pending judgement. Discard a partial window (sum/count cleared). Go to DONE.
- DONE: outputs hold until start.
- start in RUN/FLUSH and stop outside RUN are ignored. score_valid outside RUN is ignored.

## Timing
- Reset values: grade=0, grade_valid=0, combo=0, max_combo=0, total_points=0, busy=0, done=0, state IDLE. Reset takes effect immediately, asynchronously, including mid-window.
- Latency from completing sample to grade_valid: 1 cycle. combo, max_combo and total_points show updated values in the grade_valid cycle.
- start sampled at edge N: busy=1 from N+1.
- stop sampled at edge N: busy=1 through FLUSH (N+1), done=1 and busy=0 from N+2.
- Sustained throughput: one sample per cycle; one grade_valid per WINDOW samples.
- grade_valid never asserts in IDLE or DONE.

## Test plan
- WINDOW=4, default thresholds; start, then four samples of 50 back-to-back -> grade_valid one cycle after 4th sample, grade=3, combo=1, max_combo=1, total_points=100.
- Continue with 200, 300, 500, 600 (avg 400, inclusive boundary) -> grade=2, combo=2, total_points=150; no gap between windows.
- Four samples of 1001 -> grade=0, combo=0, max_combo=2, total_points=150. Four samples of 0xFFFFFFFF -> avg 0xFFFFFFFF, grade=0, no sum overflow.
- Two samples, then stop -> no grade_valid, done=1 two cycles after stop, busy=0. Later score_valid pulses leave all outputs unchanged. start clears the counters to 0.
- stop asserted together with the 4th sample (all 80) -> grade_valid=1, grade=3 in the FLUSH cycle, done=1 the following cycle.
- Assert rst asynchronously after 3 samples -> all outputs 0 before the next edge. Deassert, start, four samples of 500 -> grade=1, total_points=10 (prior partial sum discarded).
